rgb_sbit2wrd_fifo: RTL

- Parametrised successor to the serial-bit-to-word assembler in the WS2812b capture path.
- Consumes decoded bit and stream-reset strobes from the serial input detector and packs MSB-first bits into DATA_BITS-wide pixel words: 24 for G-R-B, 32 for G-R-B-W.
- Each pixel word gets an 8-bit status byte and is buffered in a first-word-fall-through FIFO with a valid/ready output handshake.
- Adds behaviour the previous block lacks: partial-pixel flagging, overflow detection, and a per-frame pixel counter.

---
 rtl/rgb_sbit2wrd_fifo.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rgb_sbit2wrd_fifo.sv
// WS2812b serial-bit to pixel-word assembler with status byte and FWFT output FIFO.
// Bits arrive MSB first; each full pixel or stream reset yields one queued word.
module rgb_sbit2wrd_fifo #(
  parameter int DATA_BITS  = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_strobe,
  input  logic                          in_sbit_value,
  input  logic                          in_stream_reset,
  output logic [DATA_BITS+7:0]          out_word,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [CNT_W-1:0]              pixel_count
);

  localparam int PW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = DATA_BITS + 8;
  localparam logic [PW-1:0]    PTR_TOP  = PW'(DATA_BITS - 1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic                 prev;
  logic                 ev;
  logic                 bit_ev;
  logic                 rst_ev;
  logic                 pixel_done;
  logic [PW-1:0]        bit_ptr;
  logic [DATA_BITS-1:0] asm_reg;
  logic [DATA_BITS-1:0] asm_bit;
  logic                 drop_pending;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 push;
  logic [WW-1:0]        push_word;
  logic [7:0]           status;
  logic                 pop;
  logic                 full;
  logic                 accept;
  logic                 drop;

  // Event detection and word formation
  always_comb begin
    ev         = in_strobe & ~prev;
    bit_ev     = ev & ~in_stream_reset;
    rst_ev     = ev & in_stream_reset;
    pixel_done = bit_ev & (bit_ptr == '0);

    asm_bit          = asm_reg;
    asm_bit[bit_ptr] = in_sbit_value;

    status    = 8'h00;
    push      = 1'b0;
    push_word = '0;
    if (pixel_done) begin
      status    = {1'b1, 1'b0, 1'b0, drop_pending, 4'b0000};
      push      = 1'b1;
      push_word = {status, asm_bit};
    end else if (rst_ev) begin
      status    = {1'b0, 1'b1, (bit_ptr != PTR_TOP), drop_pending, 4'b0000};
      push      = 1'b1;
      push_word = {status, asm_reg};
    end
  end

  // A full FIFO still takes a push when the head leaves at the same edge
  always_comb begin
    out_valid = (level != '0);
    pop       = out_valid & out_ready;
    full      = (level == LVL_FULL);
    accept    = push & (~full | pop);
    drop      = push & full & ~pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= in_strobe;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ptr     <= PTR_TOP;
      asm_reg     <= '0;
      pixel_count <= '0;
    end else if (rst_ev) begin
      bit_ptr     <= PTR_TOP;
      asm_reg     <= '0;
      pixel_count <= '0;
    end else if (bit_ev) begin
      if (bit_ptr == '0) begin
        bit_ptr <= PTR_TOP;
        asm_reg <= '0;
        if (pixel_count != CNT_MAX) pixel_count <= pixel_count + CNT_W'(1);
      end else begin
        bit_ptr <= bit_ptr - PW'(1);
        asm_reg <= asm_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      drop_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !pop)      level <= level + LW'(1);
      else if (!accept && pop) level <= level - LW'(1);

      if (drop)        drop_pending <= 1'b1;
      else if (accept) drop_pending <= 1'b0;

      // A new drop outranks a coincident clear
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_word;
  end

  always_comb begin
    out_word   = out_valid ? mem[rd_ptr] : '0;
    fifo_level = level;
  end

endmodule
